// File: rtl/axi4_wr_collect_pkg.sv
// Shared types and helpers for the passive AXI4 write-burst collector.
// The *_entry_t records describe the default 32-bit address/data, 4-bit ID build.
package axi4_wr_collect_pkg;

  localparam int BEAT_MAX       = 256;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_ID_WIDTH   = 4;
  localparam int DEF_DATA_WIDTH = 32;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_ID_WIDTH-1:0]   id;
    logic [7:0]                len;
  } aw_entry_t;

  typedef struct packed {
    logic [8:0]                beats;
    logic                      partial;
    logic [DEF_DATA_WIDTH-1:0] sig;
  } wb_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } col_state_t;

  // Beat counter increment that sticks at BEAT_MAX so overlong bursts stay visible
  function automatic logic [8:0] beat_inc(input logic [8:0] cnt);
    logic [8:0] res;
    if (cnt == 9'(BEAT_MAX)) begin
      res = cnt;
    end else begin
      res = cnt + 9'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4_wr_collect_fifo.sv
// Small synchronous FIFO with async active-low reset; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module axi4_wr_collect_fifo
  import axi4_wr_collect_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign dout      = mem_r[rd_ptr_r];

  // Storage array and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Occupancy; a simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/axi4_wr_burst_collector.sv
// Passive AXI4 write snooper: pairs each AW with its W burst and emits one summary record.
// Define AXI4_WR_COLLECT_SIG_EN to build the WDATA XOR signature (rec_sig is 0 otherwise).
module axi4_wr_burst_collector
  import axi4_wr_collect_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int WDATA_WIDTH = 32,
  parameter int ID_WIDTH    = 4,
  parameter int AW_DEPTH    = 4,
  parameter int WB_DEPTH    = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     AWVALID,
  input  logic                     AWREADY,
  input  logic [ADDR_WIDTH-1:0]    AWADDR,
  input  logic [7:0]               AWLEN,
  input  logic [ID_WIDTH-1:0]      AWID,
  input  logic                     WVALID,
  input  logic                     WREADY,
  input  logic                     WLAST,
  input  logic [WDATA_WIDTH-1:0]   WDATA,
  input  logic [WDATA_WIDTH/8-1:0] WSTRB,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [ADDR_WIDTH-1:0]    rec_addr,
  output logic [ID_WIDTH-1:0]      rec_id,
  output logic [7:0]               rec_len,
  output logic [8:0]               rec_beats,
  output logic                     rec_len_err,
  output logic                     rec_partial_strb,
  output logic [WDATA_WIDTH-1:0]   rec_sig,
  output logic                     aw_ovf,
  output logic                     wb_ovf
);

  localparam int STRB_W = WDATA_WIDTH / 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [ID_WIDTH-1:0]   id;
    logic [7:0]            len;
  } aw_slot_t;

  typedef struct packed {
    logic [8:0]             beats;
    logic                   partial;
    logic [WDATA_WIDTH-1:0] sig;
  } wb_slot_t;

  logic                   aw_hs_s;
  logic                   w_hs_s;
  logic [8:0]             beat_cnt_r;
  logic                   partial_r;
  logic [8:0]             beats_nx_s;
  logic                   partial_nx_s;
  logic [WDATA_WIDTH-1:0] sig_nx_s;
  aw_slot_t               aw_din_s;
  aw_slot_t               aw_head_s;
  wb_slot_t               wb_din_s;
  wb_slot_t               wb_head_s;
  logic                   aw_full_s;
  logic                   aw_empty_s;
  logic                   wb_full_s;
  logic                   wb_empty_s;
  logic                   pair_rdy_s;
  logic                   pop_s;
  col_state_t             state_r;
  col_state_t             state_nx_s;

  logic                   rec_valid_r;
  logic [ADDR_WIDTH-1:0]  rec_addr_r;
  logic [ID_WIDTH-1:0]    rec_id_r;
  logic [7:0]             rec_len_r;
  logic [8:0]             rec_beats_r;
  logic                   rec_len_err_r;
  logic                   rec_partial_r;
  logic [WDATA_WIDTH-1:0] rec_sig_r;
  logic                   aw_ovf_r;
  logic                   wb_ovf_r;

  assign aw_hs_s      = AWVALID & AWREADY;
  assign w_hs_s       = WVALID & WREADY;
  assign beats_nx_s   = beat_inc(beat_cnt_r);
  assign partial_nx_s = partial_r | ~(&WSTRB);
  assign pair_rdy_s   = ~aw_empty_s & ~wb_empty_s;

  assign aw_din_s = '{addr: AWADDR, id: AWID, len: AWLEN};
  assign wb_din_s = '{beats: beats_nx_s, partial: partial_nx_s, sig: sig_nx_s};

`ifdef AXI4_WR_COLLECT_SIG_EN
  logic [WDATA_WIDTH-1:0] sig_r;

  function automatic logic [WDATA_WIDTH-1:0] strb_mask(input logic [STRB_W-1:0] strb);
    logic [WDATA_WIDTH-1:0] m;
    for (int i = 0; i < STRB_W; i++) begin
      m[i*8 +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

  assign sig_nx_s = sig_r ^ (WDATA & strb_mask(WSTRB));

  // Signature accumulator, restarted after every last beat
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      sig_r <= {WDATA_WIDTH{1'b0}};
    end else if (w_hs_s) begin
      sig_r <= WLAST ? {WDATA_WIDTH{1'b0}} : sig_nx_s;
    end
  end
`else
  logic unused_wdata_s;
  assign unused_wdata_s = ^WDATA;
  assign sig_nx_s       = {WDATA_WIDTH{1'b0}};
`endif

  // Beat count and partial-strobe accumulators for the burst in flight
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      beat_cnt_r <= 9'd0;
      partial_r  <= 1'b0;
    end else if (w_hs_s) begin
      if (WLAST) begin
        beat_cnt_r <= 9'd0;
        partial_r  <= 1'b0;
      end else begin
        beat_cnt_r <= beats_nx_s;
        partial_r  <= partial_nx_s;
      end
    end
  end

  axi4_wr_collect_fifo #(
    .WIDTH ($bits(aw_slot_t)),
    .DEPTH (AW_DEPTH)
  ) u_aw_fifo (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .push  (aw_hs_s),
    .din   (aw_din_s),
    .pop   (pop_s),
    .dout  (aw_head_s),
    .full  (aw_full_s),
    .empty (aw_empty_s)
  );

  axi4_wr_collect_fifo #(
    .WIDTH ($bits(wb_slot_t)),
    .DEPTH (WB_DEPTH)
  ) u_wb_fifo (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .push  (w_hs_s & WLAST),
    .din   (wb_din_s),
    .pop   (pop_s),
    .dout  (wb_head_s),
    .full  (wb_full_s),
    .empty (wb_empty_s)
  );

  // Sticky overflow flags; a pop in the same cycle makes room, so no drop
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_ovf_r <= 1'b0;
      wb_ovf_r <= 1'b0;
    end else begin
      aw_ovf_r <= aw_ovf_r | (aw_hs_s & aw_full_s & ~pop_s);
      wb_ovf_r <= wb_ovf_r | (w_hs_s & WLAST & wb_full_s & ~pop_s);
    end
  end

  // Pairing FSM state register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state and queue pop decision
  always_comb begin
    state_nx_s = state_r;
    pop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (pair_rdy_s) begin
          pop_s      = 1'b1;
          state_nx_s = HOLD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      HOLD: begin
        if (rec_ready) begin
          if (pair_rdy_s) begin
            pop_s      = 1'b1;
            state_nx_s = HOLD;
          end else begin
            state_nx_s = IDLE;
          end
        end else begin
          state_nx_s = HOLD;
        end
      end
      default: begin
        pop_s      = 1'b0;
        state_nx_s = IDLE;
      end
    endcase
  end

  // Record register, loaded whenever a pair is popped
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rec_valid_r   <= 1'b0;
      rec_addr_r    <= {ADDR_WIDTH{1'b0}};
      rec_id_r      <= {ID_WIDTH{1'b0}};
      rec_len_r     <= 8'd0;
      rec_beats_r   <= 9'd0;
      rec_len_err_r <= 1'b0;
      rec_partial_r <= 1'b0;
      rec_sig_r     <= {WDATA_WIDTH{1'b0}};
    end else begin
      rec_valid_r <= (state_nx_s == HOLD);
      if (pop_s) begin
        rec_addr_r    <= aw_head_s.addr;
        rec_id_r      <= aw_head_s.id;
        rec_len_r     <= aw_head_s.len;
        rec_beats_r   <= wb_head_s.beats;
        rec_len_err_r <= (wb_head_s.beats != ({1'b0, aw_head_s.len} + 9'd1));
        rec_partial_r <= wb_head_s.partial;
        rec_sig_r     <= wb_head_s.sig;
      end
    end
  end

  assign rec_valid        = rec_valid_r;
  assign rec_addr         = rec_addr_r;
  assign rec_id           = rec_id_r;
  assign rec_len          = rec_len_r;
  assign rec_beats        = rec_beats_r;
  assign rec_len_err      = rec_len_err_r;
  assign rec_partial_strb = rec_partial_r;
  assign rec_sig          = rec_sig_r;
  assign aw_ovf           = aw_ovf_r;
  assign wb_ovf           = wb_ovf_r;

endmodule

// File: tb/tb_axi4_wr_burst_collector.sv
// Self-checking bench for axi4_wr_burst_collector: directed cases plus randomized
// bursts against a queue-based reference model (honours AXI4_WR_COLLECT_SIG_EN).
`timescale 1ns/1ps
module tb_axi4_wr_burst_collector;

  localparam int AW_DEPTH = 4;
  localparam int WB_DEPTH = 4;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        AWVALID = 1'b0, AWREADY = 1'b0;
  logic [31:0] AWADDR = 32'd0;
  logic [7:0]  AWLEN = 8'd0;
  logic [3:0]  AWID = 4'd0;
  logic        WVALID = 1'b0, WREADY = 1'b0, WLAST = 1'b0;
  logic [31:0] WDATA = 32'd0;
  logic [3:0]  WSTRB = 4'd0;
  logic        rec_valid, rec_ready = 1'b0;
  logic [31:0] rec_addr;
  logic [3:0]  rec_id;
  logic [7:0]  rec_len;
  logic [8:0]  rec_beats;
  logic        rec_len_err, rec_partial_strb;
  logic [31:0] rec_sig;
  logic        aw_ovf, wb_ovf;

  axi4_wr_burst_collector #(
    .ADDR_WIDTH(32), .WDATA_WIDTH(32), .ID_WIDTH(4), .AW_DEPTH(AW_DEPTH), .WB_DEPTH(WB_DEPTH)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWID(AWID),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WDATA(WDATA), .WSTRB(WSTRB),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_addr(rec_addr), .rec_id(rec_id),
    .rec_len(rec_len), .rec_beats(rec_beats), .rec_len_err(rec_len_err),
    .rec_partial_strb(rec_partial_strb), .rec_sig(rec_sig), .aw_ovf(aw_ovf), .wb_ovf(wb_ovf)
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] addr; logic [3:0] id; logic [7:0] len; } m_aw_t;
  typedef struct { int beats; bit partial; logic [31:0] sig; } m_wb_t;

  m_aw_t       m_aw[$];
  m_wb_t       m_wb[$];
  int          m_cnt = 0;
  bit          m_part = 1'b0;
  logic [31:0] m_sig = 32'd0;
  bit          m_aw_ovf = 1'b0, m_wb_ovf = 1'b0;
  int          n_rec = 0;

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = s[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      m_aw.delete(); m_wb.delete();
      m_cnt = 0; m_part = 1'b0; m_sig = 32'd0; m_aw_ovf = 1'b0; m_wb_ovf = 1'b0;
    end else begin
      if (m_aw.size() == 0 || m_wb.size() == 0) begin
        chk("no_rec", rec_valid, 1'b0);
      end else if (rec_valid) begin
        int eb;
        eb = (m_wb[0].beats > 256) ? 256 : m_wb[0].beats;
        chk("rec_addr", rec_addr, m_aw[0].addr);
        chk("rec_id", rec_id, m_aw[0].id);
        chk("rec_len", rec_len, m_aw[0].len);
        chk("rec_beats", rec_beats, eb);
        chk("rec_len_err", rec_len_err, (eb != int'(m_aw[0].len) + 1));
        chk("rec_partial", rec_partial_strb, m_wb[0].partial);
`ifdef AXI4_WR_COLLECT_SIG_EN
        chk("rec_sig", rec_sig, m_wb[0].sig);
`else
        chk("rec_sig", rec_sig, 32'd0);
`endif
        if (rec_ready) begin
          void'(m_aw.pop_front());
          void'(m_wb.pop_front());
          n_rec++;
        end
      end
      chk("aw_ovf", aw_ovf, m_aw_ovf);
      chk("wb_ovf", wb_ovf, m_wb_ovf);
      // inputs presented now are sampled at the coming rising edge
      if (AWVALID && AWREADY) begin
        if (m_aw.size() < AW_DEPTH) m_aw.push_back('{AWADDR, AWID, AWLEN});
        else m_aw_ovf = 1'b1;
      end
      if (WVALID && WREADY) begin
        m_cnt++;
        m_part = m_part | (WSTRB != 4'hF);
        m_sig  = m_sig ^ (WDATA & bmask(WSTRB));
        if (WLAST) begin
          if (m_wb.size() < WB_DEPTH) m_wb.push_back('{m_cnt, m_part, m_sig});
          else m_wb_ovf = 1'b1;
          m_cnt = 0; m_part = 1'b0; m_sig = 32'd0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int          rdy_mode = 2;  // 0 random, 1 low, 2 high
  bit          fix_en = 1'b0;
  logic [31:0] fix_d [2];

  initial begin
    forever begin
      @(posedge ACLK); #1;
      case (rdy_mode)
        0:       rec_ready = ($urandom_range(0, 1) == 1);
        1:       rec_ready = 1'b0;
        default: rec_ready = 1'b1;
      endcase
    end
  end

  task automatic do_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    bit hs;
    AWADDR = a; AWID = id; AWLEN = len;
    do begin
      AWVALID = 1'b1;
      AWREADY = ($urandom_range(0, 3) != 0);
      hs = AWREADY;
      @(posedge ACLK); #1;
    end while (!hs);
    AWVALID = 1'b0; AWREADY = 1'b0;
  endtask

  task automatic do_w(input int n, input int bad_beat, input logic [3:0] bad_strb, input bit with_last);
    bit hs;
    for (int i = 0; i < n; i++) begin
      WDATA = (fix_en && i < 2) ? fix_d[i] : $urandom;
      WSTRB = (i == bad_beat) ? bad_strb : 4'hF;
      WLAST = with_last && (i == n - 1);
      do begin
        WVALID = ($urandom_range(0, 4) != 0);
        WREADY = ($urandom_range(0, 3) != 0);
        hs = WVALID && WREADY;
        @(posedge ACLK); #1;
      end while (!hs);
    end
    WVALID = 1'b0; WREADY = 1'b0; WLAST = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!rec_valid && k < 300) begin
      @(negedge ACLK); k++;
    end
    chk(tag, rec_valid, 1'b1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((m_aw.size() != 0 || m_wb.size() != 0 || rec_valid) && k < 400) begin
      @(negedge ACLK); k++;
    end
    chk("drain", m_aw.size() + m_wb.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, rec_valid, 1'b0);
    chk({tag, "_data"}, {rec_addr, rec_id, rec_len, rec_beats, rec_len_err, rec_partial_strb}, 64'd0);
    chk({tag, "_sig"}, rec_sig, 32'd0);
    chk({tag, "_ovf"}, {aw_ovf, wb_ovf}, 2'b00);
  endtask

  initial begin
    int n0;
    repeat (3) @(posedge ACLK);
    #1;
    chk_reset_outputs("reset");
    ARESETn = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;

    // single burst, AW first, latency WLAST edge N -> valid after N+1
    do_aw(32'h1000, 4'd3, 8'd3);
    do_w(4, -1, 4'h0, 1'b1);
    @(negedge ACLK); chk("single_lat_n", rec_valid, 1'b0);
    @(negedge ACLK); chk("single_lat_n1", rec_valid, 1'b1);
    chk("single_addr", rec_addr, 32'h1000);
    chk("single_id_len", {rec_id, rec_len}, {4'd3, 8'd3});
    chk("single_beats", rec_beats, 9'd4);
    chk("single_flags", {rec_len_err, rec_partial_strb}, 2'b00);
    wait_drain();

    // W before AW: record one cycle after the AW handshake
    do_w(2, -1, 4'h0, 1'b1);
    repeat (5) @(posedge ACLK);
    #1;
    do_aw(32'h2000, 4'd1, 8'd1);
    @(negedge ACLK); chk("wfirst_lat_m", rec_valid, 1'b0);
    @(negedge ACLK); chk("wfirst_lat_m1", rec_valid, 1'b1);
    chk("wfirst_beats", rec_beats, 9'd2);
    chk("wfirst_len_err", rec_len_err, 1'b0);
    wait_drain();

    // length mismatch and partial strobe on beat 3
    do_aw(32'h3000, 4'd5, 8'd7);
    do_w(5, 2, 4'h3, 1'b1);
    wait_valid("mism_valid");
    chk("mism_beats", rec_beats, 9'd5);
    chk("mism_flags", {rec_len_err, rec_partial_strb}, 2'b11);
    wait_drain();

    // signature
    fix_d[0] = 32'hA5A5A5A5; fix_d[1] = 32'h0F0F0F0F; fix_en = 1'b1;
    do_aw(32'h4000, 4'd2, 8'd1);
    do_w(2, -1, 4'h0, 1'b1);
    fix_en = 1'b0;
    wait_valid("sig_valid");
`ifdef AXI4_WR_COLLECT_SIG_EN
    chk("sig_value", rec_sig, 32'hAAAAAAAA);
`else
    chk("sig_value", rec_sig, 32'h00000000);
`endif
    wait_drain();

    // beat counter saturation
    do_aw(32'h5000, 4'd7, 8'd200);
    do_w(258, -1, 4'h0, 1'b1);
    wait_valid("sat_valid");
    chk("sat_beats", rec_beats, 9'd256);
    chk("sat_len_err", rec_len_err, 1'b1);
    wait_drain();

    // backpressure then back-to-back
    @(negedge ACLK); rdy_mode = 1;
    for (int b = 0; b < 4; b++) begin
      do_aw(32'h6000 + 32'(b * 16), 4'(b), 8'd0);
      do_w(1, -1, 4'h0, 1'b1);
    end
    wait_valid("bp_valid");
    repeat (10) @(negedge ACLK);
    chk("bp_hold_valid", rec_valid, 1'b1);
    chk("bp_hold_addr", rec_addr, 32'h6000);
    rdy_mode = 2;
    @(posedge ACLK); #2;
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      chk("b2b_valid", rec_valid, 1'b1);
      chk("b2b_addr", rec_addr, 32'h6000 + 32'(k * 16));
    end
    @(negedge ACLK); chk("b2b_end", rec_valid, 1'b0);
    wait_drain();

    // AW overflow
    @(posedge ACLK); #1;
    for (int b = 0; b <= AW_DEPTH; b++) do_aw(32'h8000 + 32'(b * 4), 4'(b), 8'd0);
    chk("aw_ovf_set", aw_ovf, 1'b1);
    n0 = n_rec;
    for (int b = 0; b < AW_DEPTH; b++) do_w(1, -1, 4'h0, 1'b1);
    wait_drain();
    chk("ovf_rec_count", n_rec - n0, AW_DEPTH);
    chk("wb_ovf_clear", wb_ovf, 1'b0);
    repeat (5) @(posedge ACLK);
    #1;

    // reset mid-burst
    do_aw(32'h9000, 4'd6, 8'd3);
    do_w(2, -1, 4'h0, 1'b0);
    ARESETn = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge ACLK);
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    repeat (4) @(negedge ACLK);
    chk("midrst_idle", rec_valid, 1'b0);
    @(posedge ACLK); #1;
    do_aw(32'h7000, 4'd4, 8'd2);
    do_w(3, -1, 4'h0, 1'b1);
    wait_valid("fresh_valid");
    chk("fresh_addr", rec_addr, 32'h7000);
    chk("fresh_beats", rec_beats, 9'd3);
    chk("fresh_len_err", rec_len_err, 1'b0);
    wait_drain();

    // randomized bursts against the model
    rdy_mode = 0;
    for (int t = 0; t < 40; t++) begin
      int k = 0;
      int len, nb, bad, order;
      logic [31:0] a;
      while ((m_aw.size() > AW_DEPTH - 2 || m_wb.size() > WB_DEPTH - 2) && k < 200) begin
        @(posedge ACLK); #1; k++;
      end
      len   = $urandom_range(0, 15);
      nb    = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 16) : len + 1;
      bad   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1;
      order = $urandom_range(0, 2);
      a     = $urandom;
      if (order == 0) begin
        do_aw(a, 4'($urandom), 8'(len));
        do_w(nb, bad, 4'($urandom_range(0, 14)), 1'b1);
      end else if (order == 1) begin
        do_w(nb, bad, 4'($urandom_range(0, 14)), 1'b1);
        do_aw(a, 4'($urandom), 8'(len));
      end else begin
        fork
          do_aw(a, 4'($urandom), 8'(len));
          do_w(nb, bad, 4'($urandom_range(0, 14)), 1'b1);
        join
      end
    end
    rdy_mode = 2;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
